// File: rtl/alu_ejec_micro_pkg.sv
// Shared definitions for the micro execute stage: widths, opcodes, FSM states, flag layout.
package alu_ejec_micro_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_N = 1;
    localparam int F_V = 0;

    function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f      = '0;
        f[F_Z] = (res == '0);
        f[F_C] = c;
        f[F_N] = res[DATA_W-1];
        f[F_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_ejec_micro_if.sv
// Control-unit / register-bank side of the execute stage, bundled as one interface.
interface alu_ejec_micro_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] Rx;
    logic [DATA_W-1:0] Ry;
    logic              busy;
    logic              done;
    logic              W;
    logic [ADDR_W-1:0] Sel_w;
    logic [DATA_W-1:0] DW;
    logic [3:0]        flags;

    modport master (output start, op, rd, Rx, Ry,
                    input  busy, done, W, Sel_w, DW, flags);
    modport slave  (input  start, op, rd, Rx, Ry,
                    output busy, done, W, Sel_w, DW, flags);
endinterface

// File: rtl/alu_ejec_micro_mult.sv
// Sequential shift-add multiplier: one partial product per cycle, DATA_W cycles after go.
module mult_sec_micro #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] prod,
    output logic                fin
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic                run_q, run_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        acc_next = acc_q + (b_q[0] ? ({{DATA_W{1'b0}}, a_q} << cnt_q) : '0);
        run_d    = run_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (go) begin
            run_d = 1'b1;
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = '0;
        end else if (run_q) begin
            acc_d = acc_next;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) run_d = 1'b0;
        end
    end

    // prod is the post-step accumulator so the final product is usable in the fin cycle
    assign prod = acc_next;
    assign fin  = run_q && (cnt_q == LAST);

endmodule

// File: rtl/alu_ejec_micro.sv
// Execute stage of the 8-bit micro: sequencing FSM, single-cycle ALU, writeback and flag registers.
module alu_ejec_micro
    import alu_ejec_micro_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_ejec_micro_if.slave bus
);
    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0]   sel_w_q, sel_w_d;
    logic [DATA_W-1:0]   dw_q, dw_d;
    logic [3:0]          flags_q, flags_d;

    logic                mul_go;
    logic                mul_fin;
    logic [2*DATA_W-1:0] mul_prod;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic [DATA_W:0]     wide;

    mult_sec_micro #(.DATA_W(DATA_W)) u_mult (
        .clk  (clk),
        .rst  (rst),
        .go   (mul_go),
        .a    (bus.Rx),
        .b    (bus.Ry),
        .prod (mul_prod),
        .fin  (mul_fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            sel_w_q <= '0;
            dw_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            sel_w_q <= sel_w_d;
            dw_q    <= dw_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide    = {1'b0, a_q} + {1'b0, b_q};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                // the extra bit of the widened difference is the borrow (A < B unsigned)
                wide    = {1'b0, a_q} - {1'b0, b_q};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = a_q << 1;
                alu_c   = a_q[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = a_q >> 1;
                alu_c   = a_q[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        sel_w_d = sel_w_q;
        dw_d    = dw_q;
        flags_d = flags_q;
        mul_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    a_d     = bus.Rx;
                    b_d     = bus.Ry;
                    rd_d    = bus.rd;
                    mul_go  = (op_e'(bus.op) == OP_MUL);
                    state_d = mul_go ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                dw_d    = alu_res;
                flags_d = pack_flags(alu_res, alu_c, alu_v);
                sel_w_d = rd_q;
                state_d = S_WB;
            end
            S_MUL: begin
                if (mul_fin) begin
                    dw_d    = mul_prod[DATA_W-1:0];
                    flags_d = pack_flags(mul_prod[DATA_W-1:0], |mul_prod[2*DATA_W-1:DATA_W], 1'b0);
                    sel_w_d = rd_q;
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy  = (state_q == S_EXEC) || (state_q == S_MUL);
    assign bus.W     = (state_q == S_WB);
    assign bus.done  = (state_q == S_WB);
    assign bus.Sel_w = sel_w_q;
    assign bus.DW    = dw_q;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_alu_ejec_micro.sv
// Directed and random checks of alu_ejec_micro against an arithmetic reference model.
module tb_alu_ejec_micro;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ejec_micro_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    alu_ejec_micro dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // returns {Z,C,N,V, result[7:0]} computed from plain integer arithmetic
    function automatic logic [11:0] model(input int op, input int a, input int b);
        int r, c, v, sa, sb, s, z, n;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; c = 0; v = 0;
        case (op)
            0: begin
                s = a + b;   r = s % 256; c = (s > 255) ? 1 : 0;
                s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
                s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 256; c = a / 128; end
            6: begin r = a / 2; c = a % 2; end
            default: begin s = a * b; r = s % 256; c = (s > 255) ? 1 : 0; end
        endcase
        z = (r == 0) ? 1 : 0;
        n = (r >= 128) ? 1 : 0;
        return 12'((z * 8 + c * 4 + n * 2 + v) * 256 + r);
    endfunction

    task automatic run_op(input string tag, input int op, input int a, input int b,
                          input int rd, input bit poke);
        int cyc;
        logic [11:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'(op);
        bus.rd    = 3'(rd);
        bus.Rx    = 8'(a);
        bus.Ry    = 8'(b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.rd    = 3'($urandom);
        bus.Rx    = 8'($urandom);
        bus.Ry    = 8'($urandom);
        cyc = 1;
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        while (bus.W !== 1'b1 && cyc < 20) begin
            bus.start = poke && (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        check({tag, ".lat"}, 32'(cyc), (op == 7) ? 32'd9 : 32'd2);
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".busy_wb"}, 32'(bus.busy), 32'd0);
        check({tag, ".sel"}, 32'(bus.Sel_w), 32'(rd));
        check({tag, ".dw"}, 32'(bus.DW), 32'(exp[7:0]));
        check({tag, ".flags"}, 32'(bus.flags), 32'(exp[11:8]));
        bus.start = poke;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".w_off"}, 32'(bus.W), 32'd0);
        check({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, ".dw_hold"}, 32'(bus.DW), 32'(exp[7:0]));
        repeat (2) @(negedge clk);
        check({tag, ".no_extra_w"}, 32'(bus.W), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.rd    = '0;
        bus.Rx    = '0;
        bus.Ry    = '0;
        #12;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.w", 32'(bus.W), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.dw", 32'(bus.DW), 32'd0);
        check("rst.sel", 32'(bus.Sel_w), 32'd0);
        check("rst.flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf", 0, 'h7F, 'h01, 2, 1'b0);
        run_op("sub_borrow", 1, 'h05, 'h06, 1, 1'b0);
        run_op("sub_zero", 1, 'h0A, 'h0A, 3, 1'b0);
        run_op("mul_ff", 7, 'h0F, 'h11, 7, 1'b1);
        run_op("mul_ovf", 7, 'h10, 'h10, 4, 1'b1);
        run_op("shl", 5, 'h81, 'h00, 5, 1'b0);
        run_op("shr", 6, 'h81, 'h00, 6, 1'b0);
        run_op("and", 2, 'hF0, 'h3C, 0, 1'b0);
        run_op("or", 3, 'hF0, 'h3C, 1, 1'b1);
        run_op("xor", 4, 'hF0, 'h3C, 2, 1'b0);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd7;
        bus.rd    = 3'd3;
        bus.Rx    = 8'd5;
        bus.Ry    = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst.busy", 32'(bus.busy), 32'd0);
        check("mrst.w", 32'(bus.W), 32'd0);
        check("mrst.flags", 32'(bus.flags), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            check("mrst.no_w", 32'(bus.W), 32'd0);
        end
        check("mrst.flags_after", 32'(bus.flags), 32'd0);
        run_op("post_rst_add", 0, 1, 1, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
